// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_write_arbiter                                      |
// | Description : Shares the two write ports of the register file among      |
// |               NUM_REQ requesters. Up to two writes per cycle go to        |
// |               distinct registers. Priority is fixed (lower index wins),   |
// |               and an aging override bounds starvation.                    |
// | Ports       : clk, reset (async, active-high)                            |
// |               stall                  - issue nothing this cycle          |
// |               req_valid/addr/data    - packed per-requester requests     |
// |               req_ready              - combinational accept              |
// |               write_port_1/2, write_data_1/2 - registered file writes    |
// |               conflict               - registered address-clash flag     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module regfile_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 64,
  parameter int AGE_LIMIT = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         write_port_1,
  output logic [DATA_W-1:0]         write_data_1,
  output logic [ADDR_W-1:0]         write_port_2,
  output logic [DATA_W-1:0]         write_data_2,
  output logic                      conflict
);

  localparam int                c_CNT_W   = $clog2(AGE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_AGE_MAX = c_CNT_W'(AGE_LIMIT);

  logic [ADDR_W-1:0]  w_addr   [NUM_REQ];
  logic [DATA_W-1:0]  w_data   [NUM_REQ];
  logic [c_CNT_W-1:0] r_wait   [NUM_REQ];
  logic [NUM_REQ-1:0] w_nz;      // valid request to a real register
  logic [NUM_REQ-1:0] w_sink;    // valid request to register 0 (discarded)
  logic [NUM_REQ-1:0] w_urgent;

  logic [NUM_REQ-1:0] w_gnt1;
  logic [NUM_REQ-1:0] w_gnt2;
  logic               w_found1;
  logic               w_found2;
  logic [ADDR_W-1:0]  w_addr1;
  logic [ADDR_W-1:0]  w_addr2;
  logic [DATA_W-1:0]  w_data1;
  logic [DATA_W-1:0]  w_data2;
  logic               w_conf_raw;

  // Per-requester unpacking and wait counters
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_addr[gi]   = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_data[gi]   = req_data[gi*DATA_W +: DATA_W];
      assign w_nz[gi]     = req_valid[gi] && (w_addr[gi] != '0);
      assign w_sink[gi]   = req_valid[gi] && (w_addr[gi] == '0);
      assign w_urgent[gi] = (r_wait[gi] == c_AGE_MAX);

      // Counts consecutive cycles spent valid without a transfer; stalls
      // count too, so a requester ages even while the arbiter is frozen.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_wait[gi] <= '0;
        end else if (!req_valid[gi] || req_ready[gi]) begin
          r_wait[gi] <= '0;
        end else if (r_wait[gi] != c_AGE_MAX) begin
          r_wait[gi] <= r_wait[gi] + c_CNT_W'(1);
        end
      end
    end
  endgenerate

  // Walk requesters in rank order: urgent class first (pass 0), then the
  // rest (pass 1), lower index first within each pass. The first hit takes
  // slot 1. Later hits sharing slot 1's address are skipped; if such a
  // request is met before slot 2 is filled, it outranked whatever ends up
  // in slot 2 and therefore lost only to the address match.
  always_comb begin
    w_gnt1     = '0;
    w_gnt2     = '0;
    w_found1   = 1'b0;
    w_found2   = 1'b0;
    w_addr1    = '0;
    w_addr2    = '0;
    w_data1    = '0;
    w_data2    = '0;
    w_conf_raw = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_nz[i] && (w_urgent[i] == (pass == 0))) begin
          if (!w_found1) begin
            w_found1  = 1'b1;
            w_gnt1[i] = 1'b1;
            w_addr1   = w_addr[i];
            w_data1   = w_data[i];
          end else if (!w_found2) begin
            if (w_addr[i] == w_addr1) begin
              w_conf_raw = 1'b1;
            end else begin
              w_found2  = 1'b1;
              w_gnt2[i] = 1'b1;
              w_addr2   = w_addr[i];
              w_data2   = w_data[i];
            end
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!reset && !stall) begin
      req_ready = w_gnt1 | w_gnt2 | w_sink;
    end
  end

  // Unused slots drive address 0 but keep their last data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_port_1 <= '0;
      write_data_1 <= '0;
      write_port_2 <= '0;
      write_data_2 <= '0;
      conflict     <= 1'b0;
    end else begin
      conflict <= !stall && w_conf_raw;
      if (!stall && w_found1) begin
        write_port_1 <= w_addr1;
        write_data_1 <= w_data1;
      end else begin
        write_port_1 <= '0;
      end
      if (!stall && w_found2) begin
        write_port_2 <= w_addr2;
        write_data_2 <= w_data2;
      end else begin
        write_port_2 <= '0;
      end
    end
  end

endmodule
`default_nettype wire
